img_frame_ctrl: RTL and testbench

- Frame-level sequencer for the image byte stream.
- Byte stream format: 16-bit height (LSB first), 16-bit width (LSB first), then height*width RGB triples in R,G,B order.
- Paces the byte source with a valid/ready handshake and validates the header dimensions.
- Presents one pixel at a time with x/y coordinates to the downstream pixel consumer, and signals end of frame or a dimension error.

---
 rtl/img_frame_ctrl.sv | 112 +++++++++++
 tb/tb_img_frame_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_ctrl.sv
// img_frame_ctrl: parses a height/width header then presents RGB pixels with x/y coordinates.
module img_frame_ctrl #(
  parameter int MAX_DIM = 1024,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] width,
  output logic             hdr_valid,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b,
  output logic [DIM_W-1:0] pix_x,
  output logic [DIM_W-1:0] pix_y,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             err_dim
);
  typedef enum logic [2:0] {IDLE, HDR, PIX, OUT, DONE, ERR} state_t;
  localparam logic [DIM_W-1:0] MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  state_t state, state_nx;
  logic [1:0] idx;
  logic [7:0] r_cap, g_cap;
  logic [DIM_W-1:0] w_full;
  logic accept, hdr_ok, take, x_end, last_pix, restart;
  assign byte_ready = state == HDR || state == PIX;
  assign busy = state == HDR || state == PIX || state == OUT || state == DONE;
  assign frame_done = state == DONE;
  assign err_dim = state == ERR;
  assign accept = byte_valid && byte_ready;
  assign restart = start && (state == IDLE || state == ERR);
  // width is only complete once its top byte is on byte_in
  assign w_full = DIM_W'({byte_in, width[7:0]});
  assign hdr_ok = height != '0 && w_full != '0 && height <= MAX && w_full <= MAX;
  assign take = state == OUT && pix_ready;
  assign x_end = pix_x == width - ONE;
  assign last_pix = x_end && pix_y == height - ONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ERR: state_nx = start ? HDR : state;
      HDR:       state_nx = accept && idx == 2'd3 ? (hdr_ok ? PIX : ERR) : HDR;
      PIX:       state_nx = accept && idx == 2'd2 ? OUT : PIX;
      OUT:       state_nx = pix_ready ? (last_pix ? DONE : PIX) : OUT;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      r_cap <= '0;
      g_cap <= '0;
      height <= '0;
      width <= '0;
      hdr_valid <= 1'b0;
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
      pix_x <= '0;
      pix_y <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (restart) begin
        hdr_valid <= 1'b0;
        idx <= '0;
        pix_x <= '0;
        pix_y <= '0;
      end
      if (accept)
        idx <= (state == HDR && idx == 2'd3) || (state == PIX && idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (accept && state == HDR)
        case (idx)
          2'd0: height[7:0] <= byte_in;
          2'd1: height[15:8] <= byte_in;
          2'd2: width[7:0] <= byte_in;
          default: begin
            width[15:8] <= byte_in;
            hdr_valid <= hdr_ok;
          end
        endcase
      if (accept && state == PIX)
        case (idx)
          2'd0: r_cap <= byte_in;
          2'd1: g_cap <= byte_in;
          default: begin
            pix_r <= r_cap;
            pix_g <= g_cap;
            pix_b <= byte_in;
            pix_valid <= 1'b1;
          end
        endcase
      if (take) begin
        pix_valid <= 1'b0;
        if (!last_pix) begin
          pix_x <= x_end ? '0 : pix_x + ONE;
          pix_y <= x_end ? pix_y + ONE : pix_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_img_frame_ctrl.sv
// tb_img_frame_ctrl: randomized frame stimulus with a scoreboard built from the stream format rules.
module tb_img_frame_ctrl;
  logic clk = 1'b0, reset, start, byte_valid, pix_ready, byte_ready;
  logic [7:0] byte_in, pix_r, pix_g, pix_b;
  logic [15:0] height, width, pix_x, pix_y;
  logic hdr_valid, pix_valid, busy, frame_done, err_dim;
  typedef struct { int x; int y; logic [7:0] r; logic [7:0] g; logic [7:0] b; int h; int w; } pix_t;
  typedef struct { bit err; int h; int w; } ev_t;
  pix_t pq[$];
  ev_t eq[$];
  int checks = 0, errors = 0, rdy_mode = 0, gap_mode = 0;
  bit noise = 0, abort = 0;
  logic err_q = 1'b0;

  img_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .height(height), .width(width), .hdr_valid(hdr_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done),
    .err_dim(err_dim)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dims"}, {height, width, pix_x, pix_y}, 64'd0);
    chk({nm, "_ctl"}, {byte_ready, hdr_valid, pix_r, pix_g, pix_b, pix_valid, busy, frame_done, err_dim}, 64'd0);
  endtask

  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Monitor: compares presented pixels and frame outcomes against the expected queues.
  initial begin
    pix_t p;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pix_valid && pix_ready) begin
          if (pq.size() == 0) chk("pix_unexpected", 1, 0);
          else begin
            p = pq.pop_front();
            chk("pix_xy", {pix_y, pix_x}, {p.y[15:0], p.x[15:0]});
            chk("pix_rgb", {pix_r, pix_g, pix_b}, {p.r, p.g, p.b});
            chk("pix_hdr", {hdr_valid, height, width}, {1'b1, p.h[15:0], p.w[15:0]});
          end
        end
        if (frame_done) begin
          if (eq.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = eq.pop_front();
            chk("done_kind", e.err, 0);
            chk("done_hdr", {hdr_valid, height, width}, {1'b1, e.h[15:0], e.w[15:0]});
            chk("done_pix_left", pq.size(), 0);
          end
        end
        if (err_dim && !err_q) begin
          if (eq.size() == 0) chk("err_unexpected", 1, 0);
          else begin
            e = eq.pop_front();
            chk("err_kind", e.err, 1);
            chk("err_ctl", {hdr_valid, byte_ready, pix_valid}, 0);
          end
        end
      end
      err_q = err_dim;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic r;
    if (gap_mode == 1 || (gap_mode == 2 && $urandom % 2 == 1)) begin
      byte_valid = 1'b0;
      start = noise;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    byte_in = b;
    byte_valid = 1'b1;
    do begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && !abort && n < 5000);
    if (!abort) chk("byte_accept", r, 1);
    byte_valid = 1'b0;
  endtask

  // Reference: pixel i of a w-wide frame sits at (i % w, i / w); frames outside 1..1024 are errors.
  task automatic run_frame(input int h, input int w, input int pat);
    logic [7:0] bq[$];
    logic [15:0] hh, ww;
    pix_t p;
    ev_t e;
    int n;
    hh = h[15:0];
    ww = w[15:0];
    bq = '{hh[7:0], hh[15:8], ww[7:0], ww[15:8]};
    e.err = !(h > 0 && w > 0 && h <= 1024 && w <= 1024);
    e.h = h;
    e.w = w;
    eq.push_back(e);
    if (!e.err)
      for (int i = 0; i < h * w; i++) begin
        p.x = i % w;
        p.y = i / w;
        p.h = h;
        p.w = w;
        p.r = pat == 1 ? 8'(10 * (i + 1)) : pat == 2 ? 8'hAA : 8'($urandom);
        p.g = pat == 1 ? 8'(10 * (i + 2)) : pat == 2 ? 8'hBB : 8'($urandom);
        p.b = pat == 1 ? 8'(10 * (i + 3)) : pat == 2 ? 8'hCC : 8'($urandom);
        pq.push_back(p);
        bq.push_back(p.r);
        bq.push_back(p.g);
        bq.push_back(p.b);
      end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    foreach (bq[i]) if (!abort) send_byte(bq[i]);
    n = 0;
    while (busy && !abort && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!abort) chk("frame_end_busy", busy, 0);
  endtask

  initial begin
    int n;
    logic [63:0] s;
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", {byte_ready, busy}, 0);
    run_frame(2, 3, 1);
    chk("t1_hdr", {hdr_valid, height, width}, {1'b1, 16'd2, 16'd3});
    run_frame(0, 5, 0);
    chk("t2_err", {err_dim, hdr_valid, byte_ready}, 3'b100);
    run_frame(1, 1, 2);
    chk("t2_recover", {err_dim, hdr_valid}, 2'b01);
    run_frame(1, 1025, 0);
    chk("t3_err", err_dim, 1);
    run_frame(1, 1024, 0);
    chk("t3_max", {hdr_valid, width}, {1'b1, 16'd1024});
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fork
      run_frame(2, 3, 1);
      begin
        n = 0;
        while (!pix_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("stall_valid", pix_valid, 1);
        s = {pix_r, pix_g, pix_b, pix_x, pix_y};
        repeat (5) begin
          @(negedge clk);
          chk("stall_hold", {pix_r, pix_g, pix_b, pix_x, pix_y}, s);
          chk("stall_ctl", {pix_valid, byte_ready}, 2'b10);
        end
        rdy_mode = 0;
      end
    join
    gap_mode = 1;
    noise = 1;
    run_frame(2, 3, 1);
    gap_mode = 0;
    noise = 0;
    fork
      run_frame(2, 3, 1);
      begin
        n = 0;
        while (pix_x != 16'd1 && n < 500) begin
          @(negedge clk);
          n++;
        end
        chk("rst_reach", pix_x, 1);
        @(posedge clk);
        #2;
        abort = 1;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
      end
    join
    pq.delete();
    eq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    abort = 0;
    run_frame(2, 3, 1);
    gap_mode = 2;
    rdy_mode = 1;
    for (int k = 0; k < 12; k++)
      run_frame($urandom % 6 == 0 ? 0 : int'($urandom_range(1, 4)),
                $urandom % 6 == 0 ? 1025 : int'($urandom_range(1, 5)), 0);
    repeat (3) @(posedge clk);
    chk("final_pix_queue", pq.size(), 0);
    chk("final_ev_queue", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
